// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: FSM states and
// the round-robin pick function used by the arbiter.
package rr_stream_mux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Upper bound on channel count handled by rr_pick; callers zero-pad valid.
    localparam int RR_MAXN = 64;

    // First set bit of valid, searching ptr+1, ptr+2, ... modulo n.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic int rr_pick(input logic [RR_MAXN-1:0] valid, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAXN; k++) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx[5:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the next valid channel after ptr.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [RR_MAXN-1:0] valid_ext;

    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
    end

    assign idx = SELW'(rr_pick(valid_ext, int'(ptr), N));
    assign any = |valid;

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin arbitration, packet locking,
// a packet-boundary static-select mode, and a registered output stage.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int LOCK = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            force_en,
    input  logic [SELW-1:0] force_sel
);

    state_t          state_reg, state_next;
    logic [SELW-1:0] ptr_reg;
    logic [SELW-1:0] lock_ch_reg, lock_ch_next;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] arb_idx;
    logic            arb_any;
    logic            grant_ok;
    logic            can_load;
    logic            xfer;
    logic [W-1:0]    ch_data [N];
    logic [W-1:0]    grant_data;
    logic            grant_last;

    rr_arbiter #(.N(N)) u_arb (
        .valid (in_valid),
        .ptr   (ptr_reg),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Force mode only applies between packets; a locked packet always wins.
    always_comb begin
        grant    = arb_idx;
        grant_ok = arb_any;
        if (state_reg == ST_LOCKED) begin
            grant    = lock_ch_reg;
            grant_ok = 1'b1;
        end else if (force_en) begin
            grant    = force_sel;
            grant_ok = (int'(force_sel) < N);
        end
    end

    assign can_load = !out_valid || out_ready;

    // Ready is also held low while in reset so nothing is accepted then.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*W +: W];
            assign in_ready[gi] = rst_n && can_load && grant_ok && (grant == SELW'(gi));
        end
    endgenerate

    assign xfer       = |(in_valid & in_ready);
    assign grant_data = ch_data[grant];
    assign grant_last = in_last[grant];

    always_comb begin
        state_next   = state_reg;
        lock_ch_next = lock_ch_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer && !grant_last && (LOCK != 0)) begin
                    state_next   = ST_LOCKED;
                    lock_ch_next = grant;
                end
            end
            ST_LOCKED: begin
                if (xfer && grant_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            lock_ch_reg <= '0;
            ptr_reg     <= SELW'(N-1);
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_sel     <= '0;
        end else begin
            state_reg   <= state_next;
            lock_ch_reg <= lock_ch_next;
            if (xfer) begin
                ptr_reg   <= grant;
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_last  <= grant_last;
                out_sel   <= grant;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_stream_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_last, out_valid, out_ready, force_en;
    logic [1:0]  out_sel, force_sel;

    logic [23:0] d3_in_data;
    logic [2:0]  d3_in_valid, d3_in_last, d3_in_ready;
    logic [7:0]  d3_out_data;
    logic        d3_out_last, d3_out_valid, d3_out_ready, d3_force_en;
    logic [1:0]  d3_out_sel, d3_force_sel;

    int tests_run    = 0;
    int tests_failed = 0;

    // model state
    int         mptr, mlock, mout_sel, last_xfer_ch;
    bit         mout_valid, mout_last;
    logic [7:0] mout_data;

    always #5 clk = ~clk;

    rr_stream_mux #(.N(N), .W(W), .LOCK(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_last(out_last), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .force_en(force_en), .force_sel(force_sel)
    );

    rr_stream_mux #(.N(3), .W(W), .LOCK(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_last(d3_in_last), .in_ready(d3_in_ready), .out_data(d3_out_data),
        .out_last(d3_out_last), .out_sel(d3_out_sel), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .force_en(d3_force_en), .force_sel(d3_force_sel)
    );

    function automatic void m_reset();
        mptr       = N - 1;
        mlock      = -1;
        mout_valid = 0;
        mout_data  = 8'h00;
        mout_last  = 0;
        mout_sel   = 0;
    endfunction

    // Expected in_ready from the rules: lock wins, then force, then RR search.
    function automatic logic [3:0] m_ready();
        int g;
        bit ok;
        logic [3:0] one;
        g   = 0;
        ok  = 0;
        one = 4'b0001;
        if (mlock >= 0) begin
            g  = mlock;
            ok = 1;
        end else if (force_en) begin
            g  = int'(force_sel);
            ok = (g < N);
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (!ok && in_valid[c]) begin
                    g  = c;
                    ok = 1;
                end
            end
        end
        if (rst_n && (!mout_valid || out_ready) && ok) return one << g;
        return 4'b0000;
    endfunction

    // Advance one clock and update the model with what crossed at that edge.
    task automatic tick();
        logic [3:0] r;
        int g;
        r = m_ready();
        g = -1;
        last_xfer_ch = -1;
        @(posedge clk);
        for (int i = 0; i < N; i++) if (r[i] && in_valid[i]) g = i;
        if (g >= 0) begin
            mout_valid   = 1;
            mout_data    = in_data[g*8 +: 8];
            mout_last    = in_last[g];
            mout_sel     = g;
            mptr         = g;
            last_xfer_ch = g;
            if (mlock < 0) begin
                if (!in_last[g]) mlock = g;
            end else if (in_last[g]) begin
                mlock = -1;
            end
        end else if (mout_valid && out_ready) begin
            mout_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_random(input bit allow_force);
        in_valid  = 4'($urandom);
        in_last   = 4'($urandom);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
        force_en  = allow_force ? ($urandom_range(0, 3) == 0) : 1'b0;
        force_sel = 2'($urandom);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            drive_random(0);
            #1;
            tests_run++;
            if (in_ready !== m_ready()) begin
                tests_failed++;
                $display("FAIL reset_pre_ready cycle %0d: got %b expected %b", k, in_ready, m_ready());
            end
            tick();
        end
        in_valid = 4'hF;
        in_last  = 4'hF;
        rst_n    = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b expected 0/0000", out_valid, in_ready);
        end
        tests_run++;
        if (out_data !== 8'h00 || out_sel !== 2'd0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: data=%h sel=%0d last=%b expected 00/0/0", out_data, out_sel, out_last);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h44332211;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant: in_ready=%b expected 0001", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL reset_first_beat: valid=%b sel=%0d data=%h expected 1/0/11", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_rr_fairness();
        int start;
        force_en  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        start     = (mptr + 1) % N;
        for (int k = 0; k < 8; k++) begin
            in_data = $urandom;
            #1;
            tests_run++;
            if (in_ready !== m_ready()) begin
                tests_failed++;
                $display("FAIL rr_ready cycle %0d: got %b expected %b", k, in_ready, m_ready());
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 2'((start + k) % N) || out_data !== mout_data) begin
                tests_failed++;
                $display("FAIL rr_sel cycle %0d: sel=%0d data=%h expected sel=%0d data=%h",
                         k, out_sel, out_data, (start + k) % N, mout_data);
            end
        end
    endtask

    task automatic test_packet_lock();
        int b1;
        int exp_sel [4] = '{1, 1, 1, 2};
        do_reset();
        force_en  = 1'b0;
        out_ready = 1'b1;
        b1        = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = {1'b0, 1'b1, (b1 < 3), 1'b0};
            in_last  = {1'b0, 1'b1, (b1 == 2), 1'b0};
            in_data  = {8'h00, 8'h2C, 8'(8'h10 + b1), 8'h00};
            #1;
            tests_run++;
            if (in_ready !== m_ready() || (k < 3 && in_ready[2] !== 1'b0)) begin
                tests_failed++;
                $display("FAIL lock_ready cycle %0d: got %b model %b", k, in_ready, m_ready());
            end
            tick();
            if (last_xfer_ch == 1) b1++;
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_sel[k]) || out_data !== mout_data) begin
                tests_failed++;
                $display("FAIL lock_sel cycle %0d: sel=%0d data=%h expected sel=%0d data=%h",
                         k, out_sel, out_data, exp_sel[k], mout_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_data;
        logic [1:0] hold_sel;
        force_en  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'($urandom);
        in_data   = $urandom;
        tick();
        hold_data = mout_data;
        hold_sel  = 2'(mout_sel);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'($urandom) | 4'b0001;
            in_data  = $urandom;
            in_last  = 4'($urandom);
            #1;
            tests_run++;
            if (in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready cycle %0d: got %b expected 0000", k, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== hold_data || out_sel !== hold_sel) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h sel=%0d expected 1/%h/%0d",
                         k, out_valid, out_data, out_sel, hold_data, hold_sel);
            end
        end
        for (int k = 0; k < 12; k++) begin
            drive_random(0);
            out_ready = 1'b1;
            #1;
            tests_run++;
            if (in_ready !== m_ready()) begin
                tests_failed++;
                $display("FAIL bp_resume_ready cycle %0d: got %b expected %b", k, in_ready, m_ready());
            end
            tick();
            tests_run++;
            if (out_valid !== mout_valid || (mout_valid && (out_data !== mout_data || out_sel !== 2'(mout_sel)))) begin
                tests_failed++;
                $display("FAIL bp_resume_out cycle %0d: valid=%b data=%h sel=%0d expected %b/%h/%0d",
                         k, out_valid, out_data, out_sel, mout_valid, mout_data, mout_sel);
            end
        end
    endtask

    task automatic test_force();
        int b0;
        int exp_sel [4] = '{0, 0, 0, 2};
        do_reset();
        out_ready = 1'b1;
        force_en  = 1'b1;
        force_sel = 2'd2;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL force_ready: got %b expected 0100", in_ready);
        end
        tick();
        tests_run++;
        if (out_data !== 8'hA5 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL force_out: data=%h sel=%0d expected A5/2", out_data, out_sel);
        end
        do_reset();
        force_en = 1'b0;
        b0       = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = {1'b0, 1'b1, 1'b0, (b0 < 3)};
            in_last  = {1'b0, 1'b1, 1'b0, (b0 == 2)};
            in_data  = {8'h00, 8'hA5, 8'h00, 8'(8'h70 + b0)};
            if (k >= 1) begin
                force_en  = 1'b1;
                force_sel = 2'd2;
            end
            #1;
            tests_run++;
            if (in_ready !== m_ready()) begin
                tests_failed++;
                $display("FAIL force_mid_ready cycle %0d: got %b expected %b", k, in_ready, m_ready());
            end
            tick();
            if (last_xfer_ch == 0) b0++;
            tests_run++;
            if (out_sel !== 2'(exp_sel[k]) || out_data !== mout_data) begin
                tests_failed++;
                $display("FAIL force_mid_sel cycle %0d: sel=%0d data=%h expected sel=%0d data=%h",
                         k, out_sel, out_data, exp_sel[k], mout_data);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_wrap_sparse();
        do_reset();
        force_en  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        in_last   = 4'hF;
        in_data   = 32'h00009900;
        #1;
        tests_run++;
        if (in_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL sparse_ready: got %b expected 0010", in_ready);
        end
        tick();
        tests_run++;
        if (out_sel !== 2'd1 || out_data !== 8'h99) begin
            tests_failed++;
            $display("FAIL sparse_sel: sel=%0d data=%h expected 1/99", out_sel, out_data);
        end
        d3_force_en  = 1'b1;
        d3_force_sel = 2'd3;
        d3_in_valid  = 3'b111;
        d3_in_last   = 3'b111;
        d3_in_data   = 24'hABCDEF;
        for (int k = 0; k < 6; k++) begin
            d3_out_ready = 1'($urandom);
            #1;
            tests_run++;
            if (d3_in_ready !== 3'b000 || d3_out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL n3_force_oob cycle %0d: in_ready=%b out_valid=%b expected 000/0",
                         k, d3_in_ready, d3_out_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive_random(1);
            #1;
            tests_run++;
            if (in_ready !== m_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready cycle %0d: got %b expected %b", k, in_ready, m_ready());
            end
            tick();
            tests_run++;
            if (out_valid !== mout_valid ||
                (mout_valid && (out_data !== mout_data || out_sel !== 2'(mout_sel) || out_last !== mout_last))) begin
                tests_failed++;
                $display("FAIL rand_out cycle %0d: v=%b d=%h s=%0d l=%b expected %b/%h/%0d/%b",
                         k, out_valid, out_data, out_sel, out_last, mout_valid, mout_data, mout_sel, mout_last);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = '0;
        in_last      = '0;
        out_ready    = 1'b0;
        force_en     = 1'b0;
        force_sel    = '0;
        d3_in_data   = '0;
        d3_in_valid  = '0;
        d3_in_last   = '0;
        d3_out_ready = 1'b1;
        d3_force_en  = 1'b0;
        d3_force_sel = '0;
        m_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_rr_fairness();
        test_packet_lock();
        test_backpressure();
        test_force();
        test_wrap_sparse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
